so3s_seq_ctrl: RTL and testbench

Digit-serial sequencer for the so3s_1D online sum-of-three-squares datapath.
- Accepts three WIDTH-digit redundant (signed_digit) operands in parallel over a valid/ready handshake.
- Clears the datapath and streams the operand digits MSD-first, then flushes the online latency.
- Accumulates the WIDTH output digits into a parallel fixed-point result, returned over a valid/ready handshake.

---
 rtl/so3s_seq_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_so3s_seq_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/so3s_seq_ctrl.sv
// so3s_seq_ctrl: digit-serial sequencer for the so3s_1D online
// sum-of-three-squares datapath.
//
// Accepts three WIDTH-digit redundant operands over a valid/ready
// handshake. It clears the datapath for one cycle, then streams the
// operand digits MSD-first and flushes the online latency. The WIDTH
// output digits are folded into a parallel fixed-point result, which is
// returned over a second valid/ready handshake.
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   in_valid, in_ready   operand handshake
//   op_x, op_y, op_z     operands; element WIDTH-1-i holds digit i
//   dp_rst_n, dp_en      datapath reset (active-low) and enable
//   dp_x, dp_y, dp_z     current digit streamed to the datapath
//   dp_s                 datapath output digit (unsigned)
//   out_valid, out_ready result handshake
//   result               sum of dp_s_k * 2^(WIDTH-1-k), k = 0..WIDTH-1
//   busy                 controller is not idle

package so3s_pkg;
    typedef logic [1:0] signed_digit;
endpackage

module so3s_seq_ctrl
    import so3s_pkg::*;
#(
    parameter int WIDTH   = 15,
    parameter int OUT_LAT = 1,
    parameter int RES_W   = WIDTH + 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  signed_digit [WIDTH-1:0]  op_x,
    input  signed_digit [WIDTH-1:0]  op_y,
    input  signed_digit [WIDTH-1:0]  op_z,
    output logic                     dp_rst_n,
    output logic                     dp_en,
    output signed_digit              dp_x,
    output signed_digit              dp_y,
    output signed_digit              dp_z,
    input  logic [3:0]               dp_s,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RES_W-1:0]         result,
    output logic                     busy
);

    // Elaboration-time parameter sanity.
    if (OUT_LAT < 0 || OUT_LAT > 4) begin : g_bad_lat
        $error("so3s_seq_ctrl: OUT_LAT must be in 0..4");
    end
    if (RES_W < WIDTH + 4) begin : g_bad_resw
        $error("so3s_seq_ctrl: RES_W must be at least WIDTH+4");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("so3s_seq_ctrl: WIDTH must be at least 2");
    end

    // One counter spans RUN and FLUSH; it is the global cycle index g
    // measured from the first RUN cycle.
    localparam int TOTAL = WIDTH + OUT_LAT;
    localparam int GW    = $clog2(TOTAL + 1);

    localparam logic [GW-1:0] G_RUN_LAST = GW'(WIDTH - 1);
    localparam logic [GW-1:0] G_LAST     = GW'(TOTAL - 1);
    localparam logic [GW-1:0] G_CAP0     = GW'(OUT_LAT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    signed_digit [WIDTH-1:0] sx;
    signed_digit [WIDTH-1:0] sy;
    signed_digit [WIDTH-1:0] sz;

    logic [GW-1:0]    g;
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] acc_nxt;
    logic [RES_W-1:0] res_q;

    logic accept;
    logic capture;
    logic last;

    assign accept  = (state == IDLE) && in_valid;
    assign capture = ((state == RUN) || (state == FLUSH)) && (g >= G_CAP0);
    assign last    = ((state == RUN) || (state == FLUSH)) && (g == G_LAST);

    // Output digits arrive MSD-first, so each one shifts the running
    // value up one binary place before being added in.
    assign acc_nxt = {acc[RES_W-2:0], 1'b0} + RES_W'(dp_s);

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (g == G_RUN_LAST) begin
                    state_nxt = (OUT_LAT > 0) ? FLUSH : DONE;
                end
            end
            FLUSH: begin
                if (g == G_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Output logic (Moore). dp_rst_n also follows rst_n so the
    // datapath stays in reset for as long as the controller does.
    // ---------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        dp_rst_n  = rst_n;
        dp_en     = 1'b0;
        dp_x      = 2'b00;
        dp_y      = 2'b00;
        dp_z      = 2'b00;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            CLEAR: begin
                dp_rst_n = 1'b0;
            end
            RUN: begin
                dp_en = 1'b1;
                dp_x  = sx[WIDTH-1];
                dp_y  = sy[WIDTH-1];
                dp_z  = sz[WIDTH-1];
            end
            FLUSH: begin
                dp_en = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Operand shift registers, cycle counter, accumulator, result
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sx    <= '0;
            sy    <= '0;
            sz    <= '0;
            g     <= '0;
            acc   <= '0;
            res_q <= '0;
        end else begin
            if (accept) begin
                sx  <= op_x;
                sy  <= op_y;
                sz  <= op_z;
                acc <= '0;
            end
            if (state == CLEAR) begin
                g <= '0;
            end
            if (state == RUN) begin
                sx <= {sx[WIDTH-2:0], signed_digit'(2'b00)};
                sy <= {sy[WIDTH-2:0], signed_digit'(2'b00)};
                sz <= {sz[WIDTH-2:0], signed_digit'(2'b00)};
            end
            if ((state == RUN) || (state == FLUSH)) begin
                g <= g + GW'(1);
            end
            if (capture) begin
                acc <= acc_nxt;
            end
            // The final capture and the result register share one edge,
            // so result is already valid in the first DONE cycle.
            if (last) begin
                res_q <= acc_nxt;
            end
        end
    end

    assign result = res_q;

endmodule

// File: tb/tb_so3s_seq_ctrl.sv
// tb_so3s_seq_ctrl: directed + randomized bench for so3s_seq_ctrl with
// a stubbed datapath output digit.
module tb_so3s_seq_ctrl;
    import so3s_pkg::*;

    localparam int W  = 4;
    localparam int L  = 2;
    localparam int RW = W + 4;
    localparam int DW = 2 * W;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_ready;
    signed_digit [W-1:0] op_x;
    signed_digit [W-1:0] op_y;
    signed_digit [W-1:0] op_z;
    logic dp_rst_n;
    logic dp_en;
    signed_digit dp_x;
    signed_digit dp_y;
    signed_digit dp_z;
    logic [3:0] dp_s;
    logic out_valid;
    logic out_ready;
    logic [RW-1:0] result;
    logic busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    so3s_seq_ctrl #(.WIDTH(W), .OUT_LAT(L), .RES_W(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_x(op_x), .op_y(op_y), .op_z(op_z),
        .dp_rst_n(dp_rst_n), .dp_en(dp_en),
        .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z),
        .dp_s(dp_s),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Digit i of an operand sits in element W-1-i.
    function automatic signed_digit dig(input signed_digit [W-1:0] v,
                                        input int i);
        return v[W-1-i];
    endfunction

    // mode 0: random dp_s, 1: constant F, 2: dp_s = g[3:0]
    task automatic run_op(input int mode, input int hold,
                          output logic [RW-1:0] got);
        signed_digit [W-1:0] ox, oy, oz;
        logic [3:0] s [W+L];
        logic [31:0] expv;
        ox = DW'($urandom);
        oy = DW'($urandom);
        oz = DW'($urandom);
        chk("idle_in_ready", 32'(in_ready), 1);
        op_x = ox; op_y = oy; op_z = oz;
        in_valid = 1'b1;
        out_ready = 1'($urandom);
        step();
        // CLEAR cycle; later operand changes must not matter
        op_x = DW'($urandom); op_y = DW'($urandom); op_z = DW'($urandom);
        in_valid = 1'($urandom);
        dp_s = 4'($urandom);
        chk("clear_dp_rst_n", 32'(dp_rst_n), 0);
        chk("clear_dp_en", 32'(dp_en), 0);
        chk("clear_in_ready", 32'(in_ready), 0);
        chk("clear_busy", 32'(busy), 1);
        step();
        for (int g = 0; g < W + L; g++) begin
            unique case (mode)
                1: s[g] = 4'hF;
                2: s[g] = 4'(g);
                default: s[g] = 4'($urandom);
            endcase
            dp_s = s[g];
            chk("stream_dp_en", 32'(dp_en), 1);
            chk("stream_dp_rst_n", 32'(dp_rst_n), 1);
            chk("stream_dp_x", 32'(dp_x), g < W ? 32'(dig(ox, g)) : 0);
            chk("stream_dp_y", 32'(dp_y), g < W ? 32'(dig(oy, g)) : 0);
            chk("stream_dp_z", 32'(dp_z), g < W ? 32'(dig(oz, g)) : 0);
            chk("stream_in_ready", 32'(in_ready), 0);
            chk("stream_out_valid", 32'(out_valid), 0);
            in_valid = 1'($urandom);
            out_ready = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        // Digit captured at g = L + k carries weight 2^(W-1-k).
        expv = 0;
        for (int k = 0; k < W; k++) begin
            expv = expv + (32'(s[L+k]) << (W - 1 - k));
        end
        chk("done_out_valid", 32'(out_valid), 1);
        chk("done_result", 32'(result), expv);
        chk("done_dp_en", 32'(dp_en), 0);
        chk("done_dp_rst_n", 32'(dp_rst_n), 1);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_result", 32'(result), expv);
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ret_out_valid", 32'(out_valid), 0);
        chk("ret_in_ready", 32'(in_ready), 1);
        chk("ret_result_kept", 32'(result), expv);
        got = result;
    endtask

    logic [RW-1:0] r;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        dp_s = 4'h0;
        op_x = DW'($urandom);
        op_y = DW'($urandom);
        op_z = DW'($urandom);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_in_ready", 32'(in_ready), 1);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_dp_en", 32'(dp_en), 0);
            chk("rst_dp_rst_n", 32'(dp_rst_n), 0);
            chk("rst_result", 32'(result), 0);
            chk("rst_dp_x", 32'(dp_x), 0);
            chk("rst_busy", 32'(busy), 0);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        step();
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_dp_rst_n", 32'(dp_rst_n), 1);

        run_op(1, 5, r);
        chk("const_f_225", 32'(r), 225);
        run_op(2, 1, r);
        chk("align_41", 32'(r), 41);
        for (int n = 0; n < 8; n++) begin
            run_op(0, 1 + int'($urandom_range(0, 3)), r);
            step();
        end

        // Reset during RUN at digit 3
        op_x = DW'($urandom); op_y = DW'($urandom); op_z = DW'($urandom);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        for (int g = 0; g < 3; g++) begin
            dp_s = 4'($urandom);
            step();
        end
        chk("abort_in_run", 32'(dp_en), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_dp_en", 32'(dp_en), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_result", 32'(result), 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort_no_valid", 32'(out_valid), 0);
        end
        run_op(0, 2, r);
        run_op(2, 1, r);
        chk("align_41_again", 32'(r), 41);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
